// File: rtl/serial_word_loader_pkg.sv
// Shared types for the serial word loader: FIFO FSM states and occupancy codes.
package serial_word_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occupancy(input fifo_state_e s);
    case (s)
      ONE:     return OCC_ONE;
      FULL:    return OCC_FULL;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with an EMPTY/ONE/FULL state machine; head is always registered.
module word_fifo2
  import serial_word_loader_pkg::*;
#(
  parameter int INPUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [INPUT_WIDTH-1:0] push_data,
  input  logic                   pop_req,
  output logic [INPUT_WIDTH-1:0] head_data,
  output logic                   valid,
  output logic                   full,
  output logic [1:0]             count
);

  fifo_state_e            state, state_nxt;
  logic [INPUT_WIDTH-1:0] head, tail;
  logic                   pop;

  assign pop       = pop_req && (state != EMPTY);
  assign valid     = (state != EMPTY);
  assign full      = (state == FULL);
  assign count     = occupancy(state);
  assign head_data = head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Simultaneous push/pop in ONE replaces the head directly; tail only holds the second word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head <= push_data;
        ONE: begin
          if (push && pop) head <= push_data;
          else if (push)   tail <= push_data;
        end
        FULL:    if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Assembles MSB-first serial bits into INPUT_WIDTH-bit words and queues them in a 2-entry FIFO.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int INPUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_in,
  input  logic                   serial_valid,
  output logic                   serial_ready,
  input  logic                   flush,
  output logic [INPUT_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             word_count
);

  localparam int CNT_W = $clog2(INPUT_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INPUT_WIDTH - 1);

  logic [INPUT_WIDTH-1:0] shift_reg;
  logic [INPUT_WIDTH-1:0] word_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   accept, push, fifo_full;

  // Only a completing bit needs FIFO space, so stall just that one while full.
  assign serial_ready = !(fifo_full && (bit_cnt == LAST));
  assign accept       = serial_valid && serial_ready;
  assign word_next    = {shift_reg[INPUT_WIDTH-2:0], serial_in};
  assign push         = accept && !flush && (bit_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (flush) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      shift_reg <= word_next;
      bit_cnt   <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  word_fifo2 #(.INPUT_WIDTH(INPUT_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word_next),
    .pop_req   (out_ready),
    .head_data (out_data),
    .valid     (out_valid),
    .full      (fifo_full),
    .count     (word_count)
  );

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: queue-based reference model plus literal checkpoints.
module tb_serial_word_loader;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         serial_in = 1'b0, serial_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic         serial_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   word_count;

  logic         s16_in = 1'b0, s16_valid = 1'b0;
  logic         s16_ready, o16_valid;
  logic [15:0]  o16_data;
  logic [1:0]   wc16;

  serial_word_loader #(.INPUT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .serial_ready(serial_ready), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count)
  );

  serial_word_loader #(.INPUT_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .serial_in(s16_in), .serial_valid(s16_valid),
    .serial_ready(s16_ready), .flush(1'b0), .out_data(o16_data),
    .out_valid(o16_valid), .out_ready(1'b1), .word_count(wc16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: words in flight as a queue, partial word as an integer accumulator.
  logic [W-1:0] mq[$];
  int           m_bits = 0;
  int           m_acc  = 0;

  task automatic model_step();
    bit m_rdy, m_pop, m_push;
    m_rdy  = !(mq.size() == 2 && m_bits == W - 1);
    m_pop  = (mq.size() > 0) && out_ready;
    m_push = 1'b0;
    if (flush) begin
      m_bits = 0;
      m_acc  = 0;
    end else if (serial_valid && m_rdy) begin
      m_acc  = (m_acc * 2 + int'(serial_in)) % (1 << W);
      m_bits = m_bits + 1;
      if (m_bits == W) begin
        m_push = 1'b1;
        m_bits = 0;
      end
    end
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back(W'(m_acc));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_bits = 0;
      m_acc  = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("model_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("model_count", 32'(word_count), 32'(mq.size()));
    chk("model_ready", 32'(serial_ready), 32'(!(mq.size() == 2 && m_bits == W - 1)));
    if (mq.size() != 0) chk("model_data", 32'(out_data), 32'(mq[0]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    serial_valid = 1'b1;
    serial_in    = b;
    n = 0;
    while (!serial_ready && n < 20) begin
      cyc();
      n++;
    end
    if (n == 20) chk("ready_timeout", 32'(serial_ready), 32'd1);
    cyc();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits);
    logic [W-1:0] v;
    v = w;
    for (int i = 0; i < nbits; i++) send_bit(v[W-1-i]);
    serial_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] w16;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_ready", 32'(serial_ready), 32'd1);
    chk("rst16_data", 32'(o16_data), 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // single word, consumer always ready
    out_ready = 1'b1;
    send_bits(8'hDE, W);
    chk("de_valid", 32'(out_valid), 32'd1);
    chk("de_data", 32'(out_data), 32'hDE);
    cyc();
    chk("de_count_after_pop", 32'(word_count), 32'd0);

    // fill the FIFO with a stalled consumer
    out_ready = 1'b0;
    send_bits(8'hBE, W);
    send_bits(8'h15, W);
    chk("full_count", 32'(word_count), 32'd2);
    send_bits(8'hCA, W - 1);
    serial_valid = 1'b1;
    serial_in    = 1'b0;
    chk("full_ready_low", 32'(serial_ready), 32'd0);
    cyc();
    chk("full_ready_held", 32'(serial_ready), 32'd0);
    chk("full_head_stable", 32'(out_data), 32'hBE);
    out_ready = 1'b1;
    cyc();
    chk("pop1_ready", 32'(serial_ready), 32'd1);
    chk("pop1_data", 32'(out_data), 32'h15);
    cyc();
    serial_valid = 1'b0;
    chk("pop2_data", 32'(out_data), 32'hCA);
    chk("pop2_count", 32'(word_count), 32'd1);
    cyc();
    out_ready = 1'b0;
    chk("drain_count", 32'(word_count), 32'd0);

    // push and pop in the same cycle while holding one word
    send_bits(8'h24, W);
    chk("pp_head", 32'(out_data), 32'h24);
    send_bits(8'hBA, W - 1);
    out_ready = 1'b1;
    send_bit(1'b0);
    serial_valid = 1'b0;
    out_ready    = 1'b0;
    chk("pp_count", 32'(word_count), 32'd1);
    chk("pp_newhead", 32'(out_data), 32'hBA);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // flush a partial word, with a bit presented in the same cycle
    out_ready = 1'b1;
    send_bits(8'h03, 4);
    flush        = 1'b1;
    serial_valid = 1'b1;
    serial_in    = 1'b1;
    cyc();
    flush        = 1'b0;
    serial_valid = 1'b0;
    send_bits(8'h76, W);
    chk("flush_data", 32'(out_data), 32'h76);
    cyc();
    chk("flush_count", 32'(word_count), 32'd0);
    out_ready = 1'b0;

    // asynchronous reset mid-word with one word buffered
    send_bits(8'hDE, W);
    send_bits(8'h43, 5);
    chk("prerst_count", 32'(word_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(word_count), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_ready", 32'(serial_ready), 32'd1);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    send_bits(8'h43, W);
    chk("postrst_data", 32'(out_data), 32'h43);
    chk("postrst_valid", 32'(out_valid), 32'd1);
    cyc();
    out_ready = 1'b0;

    // 16-bit instance
    w16 = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      s16_valid = 1'b1;
      s16_in    = w16[15-i];
      cyc();
    end
    s16_valid = 1'b0;
    chk("w16_valid", 32'(o16_valid), 32'd1);
    chk("w16_data", 32'(o16_data), 32'hBEEF);
    cyc();
    chk("w16_count", 32'(wc16), 32'd0);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 Parameter: INPUT_WIDTH, default 8, width in bits of each assembled word; legal range 2..32.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  data bit, MSB of each word first.
- serial_valid  input  1  serial_in is valid this cycle.
- serial_ready  output  1  block accepts serial_in this cycle.
- flush  input  1  synchronous discard of the partially assembled word.
- out_data  output  INPUT_WIDTH  word at the FIFO head; feeds input_data of high_bit_search.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  downstream consumes out_data this cycle.
- word_count  output  2  FIFO occupancy, 0..2.

Function
REQ-003 A serial bit SHALL be accepted on a rising clk edge when serial_valid and serial_ready are both high.
REQ-004 Accepted bits SHALL shift into an INPUT_WIDTH-bit assembly register MSB-first; a bit counter of width $clog2(INPUT_WIDTH) SHALL track the bit position 0..INPUT_WIDTH-1.
REQ-005 Acceptance of bit INPUT_WIDTH-1 SHALL push the completed word into a 2-entry FIFO and wrap the bit counter to 0 in the same edge.
REQ-006 The FIFO SHALL be controlled by an FSM with states EMPTY, ONE and FULL:
- EMPTY: push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, with the pushed word becoming the head.
- FULL: pop -> ONE; a push is impossible in FULL (see REQ-007).
REQ-007 serial_ready SHALL be low only when the FSM is in FULL and the bit counter equals INPUT_WIDTH-1. serial_ready SHALL depend on registered state only, never on out_ready.
REQ-008 A pop SHALL occur when out_valid and out_ready are both high; out_valid SHALL equal (state != EMPTY).
REQ-009 Latency: from acceptance of the last bit at edge N into an EMPTY FIFO, out_valid and out_data SHALL be valid after edge N (one cycle).
REQ-010 Words SHALL leave in strict arrival order, and none SHALL be dropped or duplicated.
REQ-011 out_data SHALL be registered and SHALL stay stable while out_valid is high and out_ready is low.
REQ-012 flush SHALL clear the bit counter and the assembly register on the next edge and leave the FIFO contents untouched.
REQ-013 When flush and an accepted bit coincide, flush SHALL win and the bit SHALL be discarded.
REQ-014 word_count SHALL encode the FSM state as EMPTY=0, ONE=1, FULL=2.

Reset
REQ-015 While rst is high, and immediately on its assertion without waiting for clk, the FSM SHALL be EMPTY and the bit counter, assembly register and both FIFO entries SHALL be 0.
REQ-016 Reset values: out_valid=0, out_data=0, word_count=0, serial_ready=1.
REQ-017 Reset asserted mid-word or mid-transfer SHALL discard all partial and buffered data; the first bit accepted after deassertion SHALL be treated as bit 0 (MSB).

Structure
REQ-018 A shared package SHALL hold the FSM state enumeration (EMPTY/ONE/FULL) and the occupancy encoding constants.
REQ-019 The 2-entry FIFO together with its FSM SHALL be a sub-module named word_fifo2, parameterised by INPUT_WIDTH; serial assembly SHALL stay in the top module.
REQ-020 The RTL SHALL contain no latches and no combinational path from out_ready to serial_ready.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Shift 8'hDE (bits 1,1,0,1,1,1,1,0) with out_ready=1 -> out_valid=1 and out_data=8'hDE one cycle after the 8th bit, word_count returns to 0 after the pop.
- Stream 8'hBE, 8'h15, 8'hCA with out_ready=0 -> word_count=2 after the second word, serial_ready=0 while the 8th bit of 8'hCA is presented; raise out_ready -> outputs 8'hBE, 8'h15, 8'hCA in order, serial_ready returns to 1 one cycle after the first pop.
- Push and pop in the same cycle with word_count=1 (head 8'h24, incoming 8'hBA) -> word_count stays 1, the next head is 8'hBA.
- Four bits of 8'h03, then flush, then a full 8'h76 -> only 8'h76 is output.
- rst asserted after 5 bits of 8'h43 with one word (8'hDE) buffered -> out_valid=0 and word_count=0 immediately; after release, 8'h43 shifts in cleanly and is output as 8'h43.
- INPUT_WIDTH=16, stream 16'hBEEF -> out_data=16'hBEEF one cycle after the 16th bit.
